// File: rtl/am_pkg.sv
// -----------------------------------------------------------------------------
// am_pkg
// Shared constants and types for the associative-memory query datapath.
//   HV_DIM / DIMS_PER_CC  : hypervector length and dimensions handled per cycle
//   SEQ_CYCLE_COUNT       : segments swept per query
//   CTR_W                 : width of the segment counter
//   NUM_CLASSES / CLASS_W : class count and class index width
//   CNT_W                 : width of the accuracy tally counters
//   am_sched_state_t      : query scheduler FSM states
// -----------------------------------------------------------------------------
package am_pkg;

    localparam int HV_DIM          = 2048;
    localparam int DIMS_PER_CC     = 512;
    localparam int SEQ_CYCLE_COUNT = HV_DIM / DIMS_PER_CC;
    localparam int CTR_W           = $clog2(SEQ_CYCLE_COUNT);
    localparam int NUM_CLASSES     = 26;
    localparam int CLASS_W         = $clog2(NUM_CLASSES);
    localparam int CNT_W           = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPARE = 3'd1,
        INFER   = 3'd2,
        CAPTURE = 3'd3,
        RESULT  = 3'd4,
        DONE    = 3'd5
    } am_sched_state_t;

endpackage

// File: rtl/am_tally_counter.sv
// -----------------------------------------------------------------------------
// am_tally_counter
// Saturating up-counter: increments on inc_i, holds at all-ones, cleared by a
// synchronous active-high reset.
//   clk_i   : clock
//   rst_i   : synchronous reset, active-high
//   inc_i   : increment request for this cycle
//   count_o : current count (registered)
// -----------------------------------------------------------------------------
module am_tally_counter
    import am_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count up on request, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/am_query_scheduler.sv
// -----------------------------------------------------------------------------
// am_query_scheduler
// Sequences one query hypervector at a time through the associative memory:
// accepts a query + label, sweeps the segment counter, pulses class inference,
// captures the comparator winner, scores it against the label and keeps
// running accuracy tallies.
//
// Optional build macro: AM_SCHED_STALL_CNT_EN adds stall_cycles, counting
// result back-pressure cycles and IDLE cycles starved of a query.
//
// Ports:
//   clk, nrst (sync, active-high), en (global freeze when 0)
//   start_querying, query_valid/query_ready, query_label, query_last : query in
//   hv_load, query_ctr, comparing_query_hv_with_class_hv, inferring_class :
//       datapath control
//   class_inference : comparator result
//   result_valid/result_ready, result_class, result_correct : result out
//   correct_count, total_count, tallying_accuracy : accuracy tallies
//   stall_cycles (optional)
// -----------------------------------------------------------------------------
module am_query_scheduler
    import am_pkg::*;
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic               start_querying,
    input  logic               query_valid,
    output logic               query_ready,
    input  logic [CLASS_W-1:0] query_label,
    input  logic               query_last,
    output logic               hv_load,
    output logic [CTR_W-1:0]   query_ctr,
    output logic               comparing_query_hv_with_class_hv,
    output logic               inferring_class,
    input  logic [CLASS_W-1:0] class_inference,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [CLASS_W-1:0] result_class,
    output logic               result_correct,
    output logic [CNT_W-1:0]   correct_count,
    output logic [CNT_W-1:0]   total_count,
    output logic               tallying_accuracy
`ifdef AM_SCHED_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cycles
`endif
);

    localparam logic [CTR_W-1:0] LAST_SEG = CTR_W'(SEQ_CYCLE_COUNT - 1);

    am_sched_state_t    state_q;
    logic [CTR_W-1:0]   ctr_q;
    logic               hv_load_q;
    logic               comparing_q;
    logic               inferring_q;
    logic               result_valid_q;
    logic [CLASS_W-1:0] result_class_q;
    logic               result_correct_q;
    logic               tally_q;
    logic [CLASS_W-1:0] label_q;
    logic               last_q;

    logic query_ready_s;
    logic accept_s;
    logic match_s;
    logic total_inc_s;
    logic correct_inc_s;

    // Ready is combinational so the RESULT fast path can accept the next query
    // in the same cycle the current result is taken; held low in reset/freeze.
    always_comb begin
        query_ready_s = 1'b0;
        case (state_q)
            IDLE:    query_ready_s = en & ~nrst & start_querying;
            RESULT:  query_ready_s = en & ~nrst & start_querying & result_ready & ~last_q;
            default: query_ready_s = 1'b0;
        endcase
    end

    assign accept_s      = query_valid & query_ready_s;
    assign match_s       = (class_inference == label_q);
    assign total_inc_s   = en & (state_q == CAPTURE);
    assign correct_inc_s = total_inc_s & match_s;

    // Scheduler FSM with all control outputs registered.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q          <= IDLE;
            ctr_q            <= '0;
            hv_load_q        <= 1'b0;
            comparing_q      <= 1'b0;
            inferring_q      <= 1'b0;
            result_valid_q   <= 1'b0;
            result_class_q   <= '0;
            result_correct_q <= 1'b0;
            tally_q          <= 1'b0;
            label_q          <= '0;
            last_q           <= 1'b0;
        end else if (en) begin
            hv_load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        label_q     <= query_label;
                        last_q      <= query_last;
                        hv_load_q   <= 1'b1;
                        ctr_q       <= '0;
                        comparing_q <= 1'b1;
                        state_q     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (ctr_q == LAST_SEG) begin
                        ctr_q       <= '0;
                        comparing_q <= 1'b0;
                        inferring_q <= 1'b1;
                        state_q     <= INFER;
                    end else begin
                        ctr_q <= ctr_q + CTR_W'(1);
                    end
                end
                INFER: begin
                    inferring_q <= 1'b0;
                    state_q     <= CAPTURE;
                end
                CAPTURE: begin
                    result_class_q   <= class_inference;
                    result_correct_q <= match_s;
                    result_valid_q   <= 1'b1;
                    state_q          <= RESULT;
                end
                RESULT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        if (last_q) begin
                            tally_q <= 1'b1;
                            state_q <= DONE;
                        end else if (accept_s) begin
                            // Back-to-back: skip IDLE and start sweeping now.
                            label_q     <= query_label;
                            last_q      <= query_last;
                            hv_load_q   <= 1'b1;
                            ctr_q       <= '0;
                            comparing_q <= 1'b1;
                            state_q     <= COMPARE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    am_tally_counter #(.W(CNT_W)) u_total_cnt (
        .clk_i   (clk),
        .rst_i   (nrst),
        .inc_i   (total_inc_s),
        .count_o (total_count)
    );

    am_tally_counter #(.W(CNT_W)) u_correct_cnt (
        .clk_i   (clk),
        .rst_i   (nrst),
        .inc_i   (correct_inc_s),
        .count_o (correct_count)
    );

`ifdef AM_SCHED_STALL_CNT_EN
    logic stall_inc_s;

    assign stall_inc_s = en & (((state_q == RESULT) & ~result_ready) |
                               ((state_q == IDLE) & start_querying & ~query_valid));

    am_tally_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (nrst),
        .inc_i   (stall_inc_s),
        .count_o (stall_cycles)
    );
`endif

    assign query_ready                      = query_ready_s;
    assign hv_load                          = hv_load_q;
    assign query_ctr                        = ctr_q;
    assign comparing_query_hv_with_class_hv = comparing_q;
    assign inferring_class                  = inferring_q;
    assign result_valid                     = result_valid_q;
    assign result_class                     = result_class_q;
    assign result_correct                   = result_correct_q;
    assign tallying_accuracy                = tally_q;

endmodule

// File: tb/tb_am_query_scheduler.sv
module tb_am_query_scheduler;
    import am_pkg::*;

    logic               clk = 1'b0;
    logic               nrst = 1'b1;
    logic               en = 1'b1;
    logic               start_querying = 1'b0;
    logic               query_valid = 1'b0;
    logic               query_ready;
    logic [CLASS_W-1:0] query_label = '0;
    logic               query_last = 1'b0;
    logic               hv_load;
    logic [CTR_W-1:0]   query_ctr;
    logic               comparing;
    logic               inferring;
    logic [CLASS_W-1:0] class_inference = '0;
    logic               result_valid;
    logic               result_ready = 1'b0;
    logic [CLASS_W-1:0] result_class;
    logic               result_correct;
    logic [CNT_W-1:0]   correct_count;
    logic [CNT_W-1:0]   total_count;
    logic               tallying_accuracy;
`ifdef AM_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0]   stall_cycles;
`endif

    // Small saturating counter instance to exercise the all-ones hold.
    logic       sat_rst = 1'b1;
    logic       sat_inc = 1'b0;
    logic [2:0] sat_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: what the current query should produce.
    int exp_cor = 0;
    int exp_tot = 0;
    int cur_label = 0;
    int cur_inf = 0;
    bit cur_last = 1'b0;

    always #5 clk = ~clk;

    am_query_scheduler dut (
        .clk                              (clk),
        .nrst                             (nrst),
        .en                               (en),
        .start_querying                   (start_querying),
        .query_valid                      (query_valid),
        .query_ready                      (query_ready),
        .query_label                      (query_label),
        .query_last                       (query_last),
        .hv_load                          (hv_load),
        .query_ctr                        (query_ctr),
        .comparing_query_hv_with_class_hv (comparing),
        .inferring_class                  (inferring),
        .class_inference                  (class_inference),
        .result_valid                     (result_valid),
        .result_ready                     (result_ready),
        .result_class                     (result_class),
        .result_correct                   (result_correct),
        .correct_count                    (correct_count),
        .total_count                      (total_count),
        .tallying_accuracy                (tallying_accuracy)
`ifdef AM_SCHED_STALL_CNT_EN
        ,
        .stall_cycles                     (stall_cycles)
`endif
    );

    am_tally_counter #(.W(3)) u_sat (
        .clk_i   (clk),
        .rst_i   (sat_rst),
        .inc_i   (sat_inc),
        .count_o (sat_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [63:0] all_outs();
        return {18'd0, query_ready, hv_load, query_ctr, comparing, inferring, result_valid,
                result_class, result_correct, correct_count, total_count, tallying_accuracy};
    endfunction

    task automatic do_reset();
        nrst = 1'b1;
        query_valid = 1'b0;
        result_ready = 1'b0;
        step();
        step();
        check_eq("reset_outputs", all_outs(), 64'd0);
        nrst = 1'b0;
        exp_cor = 0;
        exp_tot = 0;
    endtask

    // Offer a query and wait (bounded) for acceptance; leaves the bench in the
    // first COMPARE cycle.
    task automatic offer(input int label, input int inf, input bit last, input bit expect_now);
        int waits;
        start_querying = 1'b1;
        query_valid = 1'b1;
        query_label = CLASS_W'(label);
        query_last = last;
        class_inference = CLASS_W'(inf);
        #1;
        waits = 0;
        while (!query_ready && waits < 20) begin
            step();
            waits++;
        end
        if (!query_ready) check_eq("accept_timeout", 64'd0, 64'd1);
        if (expect_now) check_eq("b2b_no_gap", 64'(waits), 64'd0);
        step();
        query_valid = 1'b0;
        cur_label = label;
        cur_inf = inf;
        cur_last = last;
        check_eq("seg0_ctr", 64'(query_ctr), 64'd0);
        check_eq("seg0_hv_load", 64'(hv_load), 64'd1);
        check_eq("seg0_comparing", 64'(comparing), 64'd1);
        check_eq("seg0_result_valid", 64'(result_valid), 64'd0);
    endtask

    // Remaining segments, inference, capture; ends in the first RESULT cycle.
    task automatic body();
        bit corr;
        for (int k = 1; k < SEQ_CYCLE_COUNT; k++) begin
            step();
            check_eq("seg_ctr", 64'(query_ctr), 64'(k));
            check_eq("seg_comparing", 64'(comparing), 64'd1);
            check_eq("seg_hv_load", 64'(hv_load), 64'd0);
            check_eq("seg_inferring", 64'(inferring), 64'd0);
        end
        step();
        check_eq("infer_pulse", 64'(inferring), 64'd1);
        check_eq("infer_comparing", 64'(comparing), 64'd0);
        check_eq("infer_ctr", 64'(query_ctr), 64'd0);
        step();
        check_eq("capture_inferring", 64'(inferring), 64'd0);
        check_eq("capture_result_valid", 64'(result_valid), 64'd0);
        step();
        corr = (cur_label == cur_inf);
        exp_tot = sat16(exp_tot + 1);
        if (corr) exp_cor = sat16(exp_cor + 1);
        check_eq("result_valid", 64'(result_valid), 64'd1);
        check_eq("result_class", 64'(result_class), 64'(cur_inf));
        check_eq("result_correct", 64'(result_correct), 64'(corr));
        check_eq("correct_count", 64'(correct_count), 64'(exp_cor));
        check_eq("total_count", 64'(total_count), 64'(exp_tot));
    endtask

    // Hold off the result for 'delay' cycles, then take it.
    task automatic finish(input int delay);
        result_ready = 1'b0;
        #1;
        for (int i = 0; i < delay; i++) begin
            check_eq("bp_query_ready", 64'(query_ready), 64'd0);
            step();
            check_eq("bp_result_valid", 64'(result_valid), 64'd1);
            check_eq("bp_result_class", 64'(result_class), 64'(cur_inf));
            check_eq("bp_total", 64'(total_count), 64'(exp_tot));
            check_eq("bp_correct", 64'(correct_count), 64'(exp_cor));
        end
        result_ready = 1'b1;
        step();
        check_eq("hs_result_valid", 64'(result_valid), 64'd0);
        check_eq("hs_tallying", 64'(tallying_accuracy), 64'(cur_last));
        if (!cur_last) check_eq("idle_query_ready", 64'(query_ready), 64'(start_querying));
    endtask

    initial begin
        int s0;
        int nsat;
        bit in_result;
        int l;
        int inf;

        // Reset state.
        start_querying = 1'b1;
        do_reset();

        // Single query, label 7 matched; start_querying dropped mid-query.
        offer(7, 7, 1'b0, 1'b0);
        start_querying = 1'b0;
        body();
        finish(0);
        check_eq("single_counts", {32'(correct_count), 32'(total_count)}, {32'd1, 32'd1});
        query_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("nostart_hv_load", 64'(hv_load), 64'd0);
            check_eq("nostart_query_ready", 64'(query_ready), 64'd0);
        end
        query_valid = 1'b0;

        // Three back-to-back queries.
        do_reset();
        result_ready = 1'b1;
        offer(3, 3, 1'b0, 1'b0);
        body();
        offer(3, 4, 1'b0, 1'b1);
        body();
        offer(9, 9, 1'b0, 1'b1);
        body();
        finish(0);
        check_eq("b2b_correct", 64'(correct_count), 64'd2);
        check_eq("b2b_total", 64'(total_count), 64'd3);

        // Back-pressure for 5 cycles.
        do_reset();
        offer(10, 11, 1'b0, 1'b0);
        body();
`ifdef AM_SCHED_STALL_CNT_EN
        s0 = int'(stall_cycles);
`endif
        finish(5);
`ifdef AM_SCHED_STALL_CNT_EN
        check_eq("stall_cycles", 64'(int'(stall_cycles) - s0), 64'd5);
`endif
        check_eq("bp_counts", {32'(correct_count), 32'(total_count)}, {32'd0, 32'd1});

        // Global enable freeze in IDLE and mid-sweep.
        en = 1'b0;
        start_querying = 1'b1;
        query_valid = 1'b1;
        #1;
        check_eq("freeze_idle_ready", 64'(query_ready), 64'd0);
        step();
        check_eq("freeze_idle_hv_load", 64'(hv_load), 64'd0);
        en = 1'b1;
        offer(4, 8, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("freeze_ctr", 64'(query_ctr), 64'd0);
            check_eq("freeze_comparing", 64'(comparing), 64'd1);
            check_eq("freeze_hv_load", 64'(hv_load), 64'd1);
        end
        en = 1'b1;
        body();
        finish(1);

        // Last query ends the dataset.
        do_reset();
        offer(5, 5, 1'b0, 1'b0);
        body();
        finish(0);
        offer(6, 2, 1'b1, 1'b0);
        body();
        finish(0);
        query_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("done_query_ready", 64'(query_ready), 64'd0);
            step();
            check_eq("done_tallying", 64'(tallying_accuracy), 64'd1);
            check_eq("done_hv_load", 64'(hv_load), 64'd0);
            check_eq("done_total", 64'(total_count), 64'd2);
        end
        query_valid = 1'b0;

        // Reset in the second COMPARE cycle, then a normal query.
        do_reset();
        offer(1, 1, 1'b0, 1'b0);
        step();
        check_eq("pre_abort_ctr", 64'(query_ctr), 64'd1);
        nrst = 1'b1;
        step();
        check_eq("abort_outputs", all_outs(), 64'd0);
        nrst = 1'b0;
        exp_cor = 0;
        exp_tot = 0;
        offer(2, 2, 1'b0, 1'b0);
        body();
        finish(0);

        // Randomized queries with random back-pressure / back-to-back.
        do_reset();
        in_result = 1'b0;
        for (int n = 0; n < 25; n++) begin
            l = int'($urandom_range(0, NUM_CLASSES - 1));
            inf = ($urandom_range(0, 1) == 0) ? l : int'($urandom_range(0, NUM_CLASSES - 1));
            if (in_result && ($urandom_range(0, 1) == 1)) begin
                result_ready = 1'b1;
                offer(l, inf, 1'b0, 1'b1);
            end else begin
                if (in_result) finish(int'($urandom_range(0, 3)));
                offer(l, inf, 1'b0, 1'b0);
            end
            body();
            in_result = 1'b1;
        end
        finish(0);

        // Saturation of the tally counter (3-bit instance holds at 7).
        sat_rst = 1'b1;
        step();
        sat_rst = 1'b0;
        check_eq("sat_reset", 64'(sat_cnt), 64'd0);
        nsat = 0;
        for (int i = 0; i < 10; i++) begin
            sat_inc = 1'b1;
            step();
            sat_inc = 1'b0;
            nsat = (nsat + 1 > 7) ? 7 : nsat + 1;
            check_eq("sat_count", 64'(sat_cnt), 64'(nsat));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/am_query_scheduler.md
Name: am_query_scheduler

Overview:
Sequences the associative-memory datapath for one query hypervector at a time. It accepts a query and its ground-truth label over a valid/ready handshake, then steps the segment counter across all sequential cycles. It pulses class inference, captures the winning class from the tree comparator, compares it with the label and keeps running accuracy tallies. The block sits between the encoder/test-vector source and the AND array, tree adders and tree comparator.

Parameters:
SEQ_CYCLE_COUNT, 4, segments per query (HV_DIM / DIMS_PER_CC)
CTR_W, 2, width of query_ctr (clog2 SEQ_CYCLE_COUNT)
CLASS_W, 5, class index width (26 classes)
CNT_W, 16, width of correct/total tally counters

Ports:
clk  in  1  clock
nrst  in  1  synchronous reset, active-high (codebase port name kept)
en  in  1  global enable; 0 freezes every register except reset
start_querying  in  1  level; arms the scheduler to leave IDLE
query_valid  in  1  query HV and label present
query_ready  out  1  scheduler accepts the query this cycle
query_label  in  CLASS_W  ground-truth class of the offered query
query_last  in  1  offered query is the last of the dataset
hv_load  out  1  one-cycle pulse; upstream registers encoded_hv on it
query_ctr  out  CTR_W  segment index driven to the mux/AND array
comparing_query_hv_with_class_hv  out  1  tree adders accumulate
inferring_class  out  1  tree comparator evaluates
class_inference  in  CLASS_W  registered comparator result
result_valid  out  1  inferred class and correctness available
result_ready  in  1  consumer takes the result
result_class  out  CLASS_W  captured class_inference
result_correct  out  1  result_class == latched label
correct_count  out  CNT_W  correct inferences since reset
total_count  out  CNT_W  completed inferences since reset
tallying_accuracy  out  1  dataset finished; counts final

Behaviour:
- Reset (nrst=1 at posedge): state IDLE; all outputs 0; counters 0; latched label and last flag 0.
- en=0: state, counters and outputs hold. Handshakes do not complete, so query_ready is forced to 0.
- IDLE: query_ready = start_querying. The query is accepted on query_valid & query_ready. On acceptance: latch the label and last flag, pulse hv_load, set query_ctr=0, and go to COMPARE.
- COMPARE: comparing flag=1 for exactly SEQ_CYCLE_COUNT cycles with query_ctr = 0,1,…,SEQ_CYCLE_COUNT-1. After the last segment, go to INFER with query_ctr reset to 0. No wrap occurs inside a query.
- INFER: inferring_class=1 for one cycle, then go to CAPTURE.
- CAPTURE: one cycle. Register result_class from class_inference and compute result_correct. Set result_valid=1, increment total_count, and increment correct_count if correct. Go to RESULT.
- RESULT: hold result_valid until result_ready. On the handshake, clear result_valid. If the latched last flag is 1, go to DONE; else go to IDLE.
- Fast path: when result_ready is already 1 in the first RESULT cycle, query_ready may also be asserted in that cycle, so a back-to-back acceptance goes straight to COMPARE.
- Accept-to-result_valid latency: SEQ_CYCLE_COUNT+2 cycles (6 at default).
- DONE: tallying_accuracy=1. Stays in DONE until reset; query_ready=0.
- Counters saturate at all-ones; they do not wrap.
- start_querying deasserted mid-query: the current query completes, and no new query is accepted.
- Reset mid-operation: abort at once to IDLE and clear all outputs. A partial accumulation is discarded because the tree adders see the comparing flag drop.

Optional Feature:
AM_SCHED_STALL_CNT_EN
- Defined: adds output stall_cycles [CNT_W-1:0]. It counts cycles in RESULT with result_ready=0, plus cycles in IDLE with start_querying=1 and query_valid=0. It saturates and is cleared by reset.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package am_pkg: SEQ_CYCLE_COUNT, DIMS_PER_CC, HV_DIM, NUM_CLASSES=26, CLASS_W, CNT_W, and the state enum am_sched_state_t {IDLE, COMPARE, INFER, CAPTURE, RESULT, DONE}.
- Sub-module: am_tally_counter, a saturating counter with enable, instanced for correct_count, total_count and the optional stall_cycles.

Test Plan:
- Reset, then a single query with label 7, and the comparator returns 7 → query_ctr sequence 0,1,2,3; inferring_class pulses once; result_valid 6 cycles after acceptance; result_correct=1; counts 1/1.
- Three back-to-back queries, result_ready held at 1, labels {3,3,9} versus comparator outputs {3,4,9} → no idle gap between queries; correct_count=2, total_count=3.
- result_ready held at 0 for 5 cycles → result_valid and result_class stable; query_ready=0; no count change until the handshake.
- query_last=1 on the 2nd query → tallying_accuracy=1 after its result handshake; further query_valid is ignored.
- nrst asserted in the 2nd COMPARE cycle → the next cycle is in IDLE, all outputs are 0, counts 0/0, and a subsequent query runs normally.
- Preload total_count to 0xFFFF with one more query → total_count stays 0xFFFF; with AM_SCHED_STALL_CNT_EN defined, 4 backpressure cycles give stall_cycles=4.
